// File: rtl/adc_axis_framer_pkg.sv
// Shared types and helpers for the ADC-to-AXI-Stream framer.
// Holds the FSM state encoding, padding-mode constants and the lane widening function.
package adc_axis_pkg;

   localparam int LANE_W = 16;

   localparam int PAD_ZERO = 0;
   localparam int PAD_SIGN = 1;
   localparam int PAD_MSB  = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   // raw is the sample already zero-extended to LANE_W; width is the real sample width
   function automatic logic [LANE_W-1:0] pad_lane(input logic [LANE_W-1:0] raw,
                                                  input int width,
                                                  input int mode);
      logic [LANE_W-1:0] mask;
      logic [LANE_W-1:0] top_bit;
      logic [LANE_W-1:0] res;
      mask    = '1;
      top_bit = LANE_W'(1) << (width - 1);
      if (width < LANE_W) begin
         mask = ~({LANE_W{1'b1}} << width);
      end
      res = raw & mask;
      if (width < LANE_W) begin
         if (mode == PAD_SIGN && (raw & top_bit) != '0) begin
            res = (raw & mask) | ~mask;
         end else if (mode == PAD_MSB) begin
            res = (raw & mask) << (LANE_W - width);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/adc_axis_framer_if.sv
// AXI-Stream beat channel between the framer and its downstream consumer.
interface adc_axis_framer_if #(
   parameter int TDATA_WIDTH = 32
);
   logic                   tvalid;
   logic                   tready;
   logic [TDATA_WIDTH-1:0] tdata;
   logic                   tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/adc_axis_framer_fifo.sv
// Single-clock FIFO with full/empty flags; a push while full succeeds when a pop happens the same cycle.
module axis_sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_rd;
   logic             do_wr;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_rd) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         if (do_wr && !do_rd) begin
            count_reg <= count_reg + CW'(1);
         end else if (!do_wr && do_rd) begin
            count_reg <= count_reg - CW'(1);
         end
      end
   end

endmodule

// File: rtl/adc_axis_framer.sv
// Packs DDR ADC sample pairs into framed AXI-Stream beats through a small FIFO
// and a registered output stage; counts beats dropped when the FIFO is full.
module adc_axis_framer
   import adc_axis_pkg::*;
#(
   parameter int DATA_WIDTH          = 14,
   parameter int NUM_CH              = 1,
   parameter int C_M_AXI_TDATA_WIDTH = 32,
   parameter int FIFO_DEPTH          = 16,
   parameter int PAD_MODE            = 0
) (
   input  logic                         m_axi_aclk,
   input  logic                         m_axi_areset,
   input  logic [NUM_CH*DATA_WIDTH-1:0] adc_q1,
   input  logic [NUM_CH*DATA_WIDTH-1:0] adc_q2,
   input  logic                         sample_valid,
   input  logic                         data_en,
   input  logic [15:0]                  frame_len,
   input  logic                         ovf_clear,
   adc_axis_framer_if.master            m_axi,
   output logic                         overflow,
   output logic [15:0]                  drop_count,
   output logic                         busy
);
   localparam int FW = C_M_AXI_TDATA_WIDTH + 1;

   state_t                         state_reg, state_next;
   logic [15:0]                    beat_cnt_reg, beat_cnt_next;
   logic [15:0]                    len_reg, len_next;
   logic [15:0]                    len_in;
   logic [15:0]                    cur_len;
   logic                           beat_last;
   logic                           wr_attempt;
   logic                           wr_ok;
   logic                           drop;
   logic [C_M_AXI_TDATA_WIDTH-1:0] beat_data;

   logic                           fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [FW-1:0]                  fifo_rd_data;
   logic                           out_free, bypass;

   logic                           tvalid_reg, tlast_reg;
   logic [C_M_AXI_TDATA_WIDTH-1:0] tdata_reg;
   logic                           overflow_reg;
   logic [15:0]                    drop_count_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_pack
         assign beat_data[gi*32 +: 32] = {
            pad_lane(LANE_W'(adc_q1[gi*DATA_WIDTH +: DATA_WIDTH]), DATA_WIDTH, PAD_MODE),
            pad_lane(LANE_W'(adc_q2[gi*DATA_WIDTH +: DATA_WIDTH]), DATA_WIDTH, PAD_MODE)
         };
      end
   endgenerate

   // A frame's length is taken live on its first beat and held for the rest
   assign len_in    = (frame_len == 16'd0) ? 16'd1 : frame_len;
   assign cur_len   = (beat_cnt_reg == 16'd0) ? len_in : len_reg;
   assign beat_last = ((beat_cnt_reg + 16'd1) == cur_len);

   assign out_free  = !tvalid_reg || m_axi.tready;
   assign fifo_pop  = out_free && !fifo_empty;
   assign bypass    = out_free && fifo_empty;
   assign wr_ok     = wr_attempt && (bypass || !fifo_full || fifo_pop);
   assign drop      = wr_attempt && !wr_ok;
   assign fifo_push = wr_ok && !bypass;

   always_comb begin
      state_next    = state_reg;
      beat_cnt_next = beat_cnt_reg;
      len_next      = len_reg;
      wr_attempt    = 1'b0;
      unique case (state_reg)
         ST_IDLE:   wr_attempt = sample_valid && data_en;
         // With capture disabled on a frame boundary no new frame is started
         ST_RUN:    wr_attempt = sample_valid && (data_en || beat_cnt_reg != 16'd0);
         ST_FINISH: wr_attempt = sample_valid;
         default:   wr_attempt = 1'b0;
      endcase
      if (wr_attempt && beat_cnt_reg == 16'd0) begin
         len_next = len_in;
      end
      if (wr_ok) begin
         beat_cnt_next = beat_last ? 16'd0 : beat_cnt_reg + 16'd1;
      end
      unique case (state_reg)
         ST_IDLE: begin
            if (data_en && sample_valid) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (!data_en) state_next = (beat_cnt_next == 16'd0) ? ST_IDLE : ST_FINISH;
         end
         ST_FINISH: begin
            if (data_en) state_next = ST_RUN;
            else if (beat_cnt_next == 16'd0) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         state_reg    <= ST_IDLE;
         beat_cnt_reg <= 16'd0;
         len_reg      <= 16'd0;
      end else begin
         state_reg    <= state_next;
         beat_cnt_reg <= beat_cnt_next;
         len_reg      <= len_next;
      end
   end

   axis_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (m_axi_aclk),
      .srst    (m_axi_areset),
      .wr_en   (fifo_push),
      .wr_data ({beat_last, beat_data}),
      .full    (fifo_full),
      .rd_en   (fifo_pop),
      .rd_data (fifo_rd_data),
      .empty   (fifo_empty)
   );

   // An empty FIFO lets a new beat go straight into the output register
   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         tvalid_reg <= 1'b0;
         tlast_reg  <= 1'b0;
         tdata_reg  <= '0;
      end else if (out_free) begin
         if (!fifo_empty) begin
            {tlast_reg, tdata_reg} <= fifo_rd_data;
            tvalid_reg             <= 1'b1;
         end else if (wr_ok) begin
            {tlast_reg, tdata_reg} <= {beat_last, beat_data};
            tvalid_reg             <= 1'b1;
         end else begin
            tvalid_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         overflow_reg   <= 1'b0;
         drop_count_reg <= 16'd0;
      end else if (ovf_clear) begin
         overflow_reg   <= drop;
         drop_count_reg <= drop ? 16'd1 : 16'd0;
      end else if (drop) begin
         overflow_reg <= 1'b1;
         if (drop_count_reg != 16'hFFFF) begin
            drop_count_reg <= drop_count_reg + 16'd1;
         end
      end
   end

   assign m_axi.tvalid = tvalid_reg;
   assign m_axi.tdata  = tdata_reg;
   assign m_axi.tlast  = tlast_reg;
   assign overflow     = overflow_reg;
   assign drop_count   = drop_count_reg;
   assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_adc_axis_framer.sv
// Directed bench for adc_axis_framer: padding, framing, FINISH handling, overflow,
// mid-frame reset and a randomly throttled stream checked against a scoreboard.
module tb_adc_axis_framer;
   localparam int DW  = 14;
   localparam int NCH = 2;
   localparam int TW  = 64;
   localparam int FD  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              sample_valid, data_en, ovf_clear, tready;
   logic [NCH*DW-1:0] adc_q1, adc_q2;
   logic [15:0]       frame_len;
   logic              ovf_a, ovf_b, busy_a, busy_b;
   logic [15:0]       dc_a, dc_b;
   int                checks = 0;
   int                errors = 0;

   always #5 clk = ~clk;

   adc_axis_framer_if #(.TDATA_WIDTH(TW)) a_if ();
   adc_axis_framer_if #(.TDATA_WIDTH(TW)) b_if ();
   assign a_if.tready = tready;
   assign b_if.tready = tready;

   adc_axis_framer #(
      .DATA_WIDTH(DW), .NUM_CH(NCH), .C_M_AXI_TDATA_WIDTH(TW), .FIFO_DEPTH(FD), .PAD_MODE(1)
   ) dut_a (
      .m_axi_aclk(clk), .m_axi_areset(rst), .adc_q1(adc_q1), .adc_q2(adc_q2),
      .sample_valid(sample_valid), .data_en(data_en), .frame_len(frame_len),
      .ovf_clear(ovf_clear), .m_axi(a_if), .overflow(ovf_a), .drop_count(dc_a), .busy(busy_a)
   );

   adc_axis_framer #(
      .DATA_WIDTH(DW), .NUM_CH(NCH), .C_M_AXI_TDATA_WIDTH(TW), .FIFO_DEPTH(FD), .PAD_MODE(2)
   ) dut_b (
      .m_axi_aclk(clk), .m_axi_areset(rst), .adc_q1(adc_q1), .adc_q2(adc_q2),
      .sample_valid(sample_valid), .data_en(data_en), .frame_len(frame_len),
      .ovf_clear(ovf_clear), .m_axi(b_if), .overflow(ovf_b), .drop_count(dc_b), .busy(busy_b)
   );

   // Output must hold while stalled; compares each negedge against the previous one
   logic          stall_prev = 1'b0;
   logic          rst_prev   = 1'b1;
   logic [TW:0]   held;
   always @(negedge clk) begin
      if (stall_prev && !rst_prev) begin
         checks++;
         if (a_if.tvalid !== 1'b1 || {a_if.tlast, a_if.tdata} !== held) begin
            errors++;
            $display("FAIL axis_stable got v=%0b %h want v=1 %h", a_if.tvalid,
                     {a_if.tlast, a_if.tdata}, held);
         end
      end
      stall_prev <= a_if.tvalid && !tready;
      held       <= {a_if.tlast, a_if.tdata};
      rst_prev   <= rst;
   end

   function automatic logic [15:0] sx14(input logic [13:0] v);
      return {{2{v[13]}}, v};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sample(input logic [13:0] q1c0, input logic [13:0] q2c0,
                             input logic [13:0] q1c1, input logic [13:0] q2c1);
      adc_q1       = {q1c1, q1c0};
      adc_q2       = {q2c1, q2c0};
      sample_valid = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1; sample_valid = 1'b0; data_en = 1'b0; ovf_clear = 1'b0; tready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      tick();
      checks++;
      if ({a_if.tvalid, a_if.tlast, busy_a, ovf_a} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags got v/l/busy/ovf=%b want 0000",
                  {a_if.tvalid, a_if.tlast, busy_a, ovf_a});
      end
      checks++;
      if (a_if.tdata !== 64'h0 || dc_a !== 16'h0) begin
         errors++;
         $display("FAIL reset_data got tdata=%h drops=%0d want 0 0", a_if.tdata, dc_a);
      end
      rst = 1'b0;
      $display("reset: outputs after reset v=%0b busy=%0b", a_if.tvalid, busy_a);
   endtask

   task automatic test_padding();
      do_reset();
      frame_len = 16'd0;
      data_en   = 1'b1;
      set_sample(14'h2000, 14'h1FFF, 14'h3FFF, 14'h0001);
      tick();
      sample_valid = 1'b0;
      data_en      = 1'b0;
      checks++;
      if (a_if.tvalid !== 1'b1 || a_if.tdata !== 64'hFFFF0001_E0001FFF) begin
         errors++;
         $display("FAIL pad_sign got v=%0b %h want v=1 ffff0001e0001fff", a_if.tvalid, a_if.tdata);
      end
      checks++;
      if (a_if.tlast !== 1'b1) begin
         errors++;
         $display("FAIL pad_len0_tlast got %0b want 1", a_if.tlast);
      end
      checks++;
      if (b_if.tvalid !== 1'b1 || b_if.tdata !== 64'hFFFC0004_80007FFC) begin
         errors++;
         $display("FAIL pad_msb got v=%0b %h want v=1 fffc000480007ffc", b_if.tvalid, b_if.tdata);
      end
      $display("padding: sign=%h msb=%h", a_if.tdata, b_if.tdata);
      tick();
      checks++;
      if (a_if.tvalid !== 1'b0 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL pad_idle got v=%0b busy=%0b want 0 0", a_if.tvalid, busy_a);
      end
   endtask

   task automatic test_frame_len4();
      logic [63:0] exp_data;
      logic        exp_last;
      do_reset();
      frame_len = 16'd4;
      data_en   = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         set_sample(14'(i), 14'h0, 14'h0, 14'h0);
         tick();
         exp_data = 64'(i) << 16;
         exp_last = (i == 4 || i == 8);
         checks++;
         if (a_if.tvalid !== 1'b1 || a_if.tdata !== exp_data || a_if.tlast !== exp_last) begin
            errors++;
            $display("FAIL len4_beat%0d got v=%0b %h last=%0b want v=1 %h last=%0b", i,
                     a_if.tvalid, a_if.tdata, a_if.tlast, exp_data, exp_last);
         end
         $display("len4: beat %0d data %h last %0b", i, a_if.tdata, a_if.tlast);
      end
      sample_valid = 1'b0;
      data_en      = 1'b0;
      tick();
      checks++;
      if (dc_a !== 16'd0 || busy_a !== 1'b1 || a_if.tvalid !== 1'b0) begin
         errors++;
         $display("FAIL len4_after got drops=%0d busy=%0b v=%0b want 0 1 0", dc_a, busy_a, a_if.tvalid);
      end
   endtask

   task automatic test_finish();
      logic [4:0] en_pat;
      do_reset();
      frame_len = 16'd8;
      for (int i = 1; i <= 8; i++) begin
         data_en = (i <= 3);
         set_sample(14'(i + 16), 14'h0, 14'h0, 14'h0);
         tick();
         checks++;
         if (a_if.tdata !== (64'(i + 16) << 16) || a_if.tlast !== (i == 8) ||
             busy_a !== (i != 8)) begin
            errors++;
            $display("FAIL finish_beat%0d got %h last=%0b busy=%0b want %h last=%0b busy=%0b", i,
                     a_if.tdata, a_if.tlast, busy_a, 64'(i + 16) << 16, (i == 8), (i != 8));
         end
         $display("finish: beat %0d last %0b busy %0b", i, a_if.tlast, busy_a);
      end
      set_sample(14'h7, 14'h0, 14'h0, 14'h0);
      tick();
      checks++;
      if (a_if.tvalid !== 1'b0) begin
         errors++;
         $display("FAIL finish_idle_ignore got v=%0b want 0", a_if.tvalid);
      end
      frame_len = 16'd4;
      en_pat    = 5'b11101;
      for (int i = 1; i <= 5; i++) begin
         data_en = en_pat[i-1];
         set_sample(14'(i + 32), 14'h0, 14'h0, 14'h0);
         tick();
         checks++;
         if (a_if.tvalid !== 1'b1 || a_if.tlast !== (i == 4) || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL reenter_beat%0d got v=%0b last=%0b busy=%0b want 1 %0b 1", i,
                     a_if.tvalid, a_if.tlast, busy_a, (i == 4));
         end
         $display("reenter: beat %0d last %0b", i, a_if.tlast);
      end
      sample_valid = 1'b0;
      data_en      = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      tready    = 1'b0;
      frame_len = 16'd16;
      data_en   = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         set_sample(14'(i), 14'h0, 14'h0, 14'h0);
         tick();
      end
      sample_valid = 1'b0;
      checks++;
      if (ovf_a !== 1'b1 || dc_a !== 16'd2) begin
         errors++;
         $display("FAIL ovf_count got ovf=%0b drops=%0d want 1 2", ovf_a, dc_a);
      end
      tick();
      tick();
      tready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         checks++;
         if (a_if.tvalid !== 1'b1 || a_if.tdata !== (64'(i) << 16)) begin
            errors++;
            $display("FAIL ovf_drain%0d got v=%0b %h want v=1 %h", i, a_if.tvalid, a_if.tdata,
                     64'(i) << 16);
         end
         $display("overflow: drain beat %0d data %h", i, a_if.tdata);
         tick();
      end
      checks++;
      if (a_if.tvalid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_drained got v=%0b want 0", a_if.tvalid);
      end
      tready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         set_sample(14'(i + 32), 14'h0, 14'h0, 14'h0);
         tick();
      end
      ovf_clear = 1'b1;
      tick();
      ovf_clear    = 1'b0;
      sample_valid = 1'b0;
      checks++;
      if (ovf_a !== 1'b1 || dc_a !== 16'd1) begin
         errors++;
         $display("FAIL ovf_clear_drop got ovf=%0b drops=%0d want 1 1", ovf_a, dc_a);
      end
      tready = 1'b1;
      set_sample(14'h40, 14'h0, 14'h0, 14'h0);
      tick();
      sample_valid = 1'b0;
      checks++;
      if (dc_a !== 16'd1) begin
         errors++;
         $display("FAIL full_rw_nodrop got drops=%0d want 1", dc_a);
      end
      ovf_clear = 1'b1;
      tick();
      ovf_clear = 1'b0;
      checks++;
      if (ovf_a !== 1'b0 || dc_a !== 16'd0) begin
         errors++;
         $display("FAIL ovf_clear got ovf=%0b drops=%0d want 0 0", ovf_a, dc_a);
      end
      data_en = 1'b0;
   endtask

   task automatic test_reset_midframe();
      do_reset();
      frame_len = 16'd8;
      data_en   = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         set_sample(14'(i), 14'h0, 14'h0, 14'h0);
         tick();
      end
      rst          = 1'b1;
      sample_valid = 1'b0;
      tick();
      rst = 1'b0;
      checks++;
      if ({a_if.tvalid, a_if.tlast, busy_a} !== 3'b0 || a_if.tdata !== 64'h0) begin
         errors++;
         $display("FAIL midrst_outputs got v/l/busy=%b tdata=%h want 000 0",
                  {a_if.tvalid, a_if.tlast, busy_a}, a_if.tdata);
      end
      frame_len = 16'd2;
      set_sample(14'h11, 14'h0, 14'h0, 14'h0);
      tick();
      checks++;
      if (a_if.tvalid !== 1'b1 || a_if.tdata !== 64'h11_0000 || a_if.tlast !== 1'b0) begin
         errors++;
         $display("FAIL midrst_beat1 got v=%0b %h last=%0b want 1 110000 0", a_if.tvalid,
                  a_if.tdata, a_if.tlast);
      end
      set_sample(14'h12, 14'h0, 14'h0, 14'h0);
      tick();
      checks++;
      if (a_if.tdata !== 64'h12_0000 || a_if.tlast !== 1'b1) begin
         errors++;
         $display("FAIL midrst_beat2 got %h last=%0b want 120000 1", a_if.tdata, a_if.tlast);
      end
      $display("midreset: new frame beat 2 last %0b", a_if.tlast);
      sample_valid = 1'b0;
      data_en      = 1'b0;
   endtask

   task automatic test_random();
      logic [64:0] exp_q[$];
      logic [64:0] exp;
      logic [13:0] r0, r1, r2, r3;
      int          pushed = 0;
      int          popped = 0;
      int          cyc    = 0;
      int          outst;
      do_reset();
      frame_len = 16'd5;
      data_en   = 1'b1;
      while (popped < 1000 && cyc < 20000) begin
         outst  = pushed - popped;
         tready = 1'($urandom_range(0, 1));
         if (a_if.tvalid && tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rand_extra got %h want no beat", {a_if.tlast, a_if.tdata});
            end else begin
               exp = exp_q.pop_front();
               if ({a_if.tlast, a_if.tdata} !== exp) begin
                  errors++;
                  $display("FAIL rand_beat%0d got %h want %h", popped,
                           {a_if.tlast, a_if.tdata}, exp);
               end
            end
            popped++;
         end
         if (pushed < 1000 && outst < 4 && $urandom_range(0, 1) == 1) begin
            r0 = 14'($urandom); r1 = 14'($urandom); r2 = 14'($urandom); r3 = 14'($urandom);
            set_sample(r0, r1, r2, r3);
            exp_q.push_back({(pushed % 5 == 4), sx14(r2), sx14(r3), sx14(r0), sx14(r1)});
            pushed++;
         end else begin
            sample_valid = 1'b0;
         end
         tick();
         cyc++;
      end
      sample_valid = 1'b0;
      data_en      = 1'b0;
      tready       = 1'b1;
      checks++;
      if (popped != 1000) begin
         errors++;
         $display("FAIL rand_count got %0d beats want 1000", popped);
      end
      checks++;
      if (dc_a !== 16'd0) begin
         errors++;
         $display("FAIL rand_drops got %0d want 0", dc_a);
      end
      $display("random: %0d beats in %0d cycles", popped, cyc);
   endtask

   initial begin
      rst = 1'b1; sample_valid = 1'b0; data_en = 1'b0; ovf_clear = 1'b0; tready = 1'b1;
      adc_q1 = '0; adc_q2 = '0; frame_len = 16'd1;
      test_reset();
      test_padding();
      test_frame_len4();
      test_finish();
      test_overflow();
      test_reset_midframe();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
